// File: rtl/coin_lane_scheduler.sv
// Three-lane coin scheduler: frame-rate spawn, fall, scale, collect/miss and score.
// Optional macro COIN_SCHED_SPEEDUP_EN shortens the spawn interval as coins are collected.
module coin_lane_scheduler #(
   parameter int unsigned SPAWN_INTERVAL = 120,
   parameter int unsigned Y_END          = 592,
   parameter int unsigned Y_X2           = 300,
   parameter int unsigned Y_X4           = 450,
   parameter int unsigned HIT_Y_MIN      = 144,
   parameter int unsigned CENTER_X       = 640,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_v_sync,
   input  logic        i_enable,
   input  logic [2:0]  i_collect,
   output logic [2:0]  o_lane_active,
   output logic [47:0] o_lane_y,
   output logic [47:0] o_lane_x,
   output logic [5:0]  o_lane_scale,
   output logic        o_collect_pulse,
   output logic        o_miss_pulse,
   output logic [15:0] o_score
);

   typedef enum logic {
      LANE_IDLE = 1'b0,
      LANE_FALL = 1'b1
   } lane_state_e;

   localparam logic [7:0]  INTERVAL_L = 8'(SPAWN_INTERVAL);
   localparam logic [15:0] Y_END_L    = 16'(Y_END);
   localparam logic [15:0] Y_X2_L     = 16'(Y_X2);
   localparam logic [15:0] Y_X4_L     = 16'(Y_X4);
   localparam logic [15:0] HIT_Y_L    = 16'(HIT_Y_MIN);
   localparam logic [15:0] CENTER_L   = 16'(CENTER_X);

   lane_state_e state_q [3];
   lane_state_e state_d [3];
   logic [15:0] y_q [3];
   logic [15:0] y_d [3];

   logic        v_sync_q;
   logic        armed_q;
   logic [7:0]  spawn_cnt_q, spawn_cnt_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [15:0] score_q, score_d;
   logic        collect_pulse_q, collect_pulse_d;
   logic        miss_pulse_q, miss_pulse_d;

   logic        tick;
   logic [3:0]  busy;
   logic [2:0]  hit;
   logic [2:0]  miss;
   logic [1:0]  n_hit;
   logic [7:0]  interval;
   logic        spawn_due;
   logic        spawn_ok;
   logic [1:0]  pref_lane;
   logic [1:0]  spawn_lane;

   function automatic logic [1:0] next_lane(input logic [1:0] l);
      return (l == 2'd2) ? 2'd0 : l + 2'd1;
   endfunction

   // armed_q keeps a v_sync already high at reset release from looking like an edge
   assign tick = armed_q & i_v_sync & ~v_sync_q;

   assign busy  = {1'b1, state_q[2] == LANE_FALL, state_q[1] == LANE_FALL,
                   state_q[0] == LANE_FALL};
   assign n_hit = 2'($countones(hit));

`ifdef COIN_SCHED_SPEEDUP_EN
   localparam logic [7:0] INTERVAL_FLOOR = 8'd30;

   logic [7:0] interval_q, interval_d;
   logic [2:0] coin_grp_q, coin_grp_d;
   logic [3:0] grp_sum;

   assign interval = interval_q;

   always_comb begin
      grp_sum    = {1'b0, coin_grp_q} + {2'b00, n_hit};
      coin_grp_d = grp_sum[2:0];
      interval_d = interval_q;
      if (grp_sum[3] && (interval_q > INTERVAL_FLOOR)) begin
         interval_d = interval_q - 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         interval_q <= INTERVAL_L;
         coin_grp_q <= 3'd0;
      end else begin
         interval_q <= interval_d;
         coin_grp_q <= coin_grp_d;
      end
   end
`else
   assign interval = INTERVAL_L;
`endif

   // Spawn decision looks only at lane state registered at cycle start
   always_comb begin
      pref_lane  = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
      spawn_lane = pref_lane;
      spawn_ok   = 1'b1;
      if (!busy[pref_lane]) begin
         spawn_lane = pref_lane;
      end else if (!busy[next_lane(pref_lane)]) begin
         spawn_lane = next_lane(pref_lane);
      end else if (!busy[next_lane(next_lane(pref_lane))]) begin
         spawn_lane = next_lane(next_lane(pref_lane));
      end else begin
         spawn_ok = 1'b0;
      end
   end

   assign spawn_due = tick & i_enable & (spawn_cnt_q >= (interval - 8'd1));

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit  = '0;
      miss = '0;
      for (int n = 0; n < 3; n++) begin
         state_d[n] = state_q[n];
         y_d[n]     = y_q[n];
         hit[n]     = busy[n] & i_collect[n] & (y_q[n] >= HIT_Y_L);
         miss[n]    = tick & busy[n] & (y_q[n] >= Y_END_L) & ~hit[n];
         if (hit[n] || miss[n]) begin
            state_d[n] = LANE_IDLE;
            y_d[n]     = 16'd0;
         end else if (tick && busy[n]) begin
            y_d[n] = y_q[n] + 16'd1;
         end
         if (spawn_due && spawn_ok && (spawn_lane == 2'(n))) begin
            state_d[n] = LANE_FALL;
            y_d[n]     = 16'd0;
         end
      end
   end

   always_comb begin
      logic [16:0] score_sum;
      spawn_cnt_d = spawn_cnt_q;
      if (tick && i_enable) begin
         spawn_cnt_d = spawn_due ? 8'd0 : spawn_cnt_q + 8'd1;
      end
      lfsr_d = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
      score_sum       = {1'b0, score_q} + {15'd0, n_hit};
      score_d         = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      collect_pulse_d = |hit;
      miss_pulse_d    = |miss;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   // NOTE: the lane y array is only three words, so it is reset like any other register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int n = 0; n < 3; n++) begin
            state_q[n] <= LANE_IDLE;
            y_q[n]     <= 16'd0;
         end
         v_sync_q        <= 1'b0;
         armed_q         <= 1'b0;
         spawn_cnt_q     <= 8'd0;
         lfsr_q          <= LFSR_SEED;
         score_q         <= 16'd0;
         collect_pulse_q <= 1'b0;
         miss_pulse_q    <= 1'b0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            state_q[n] <= state_d[n];
            y_q[n]     <= y_d[n];
         end
         v_sync_q        <= i_v_sync;
         armed_q         <= 1'b1;
         spawn_cnt_q     <= spawn_cnt_d;
         lfsr_q          <= lfsr_d;
         score_q         <= score_d;
         collect_pulse_q <= collect_pulse_d;
         miss_pulse_q    <= miss_pulse_d;
      end
   end

   // Sprite geometry: x and scale are pure functions of the registered depth
   always_comb begin
      logic [15:0] yv;
      logic [15:0] half_y;
      logic [15:0] h;
      logic [1:0]  sc;
      logic [15:0] xv;
      o_lane_y     = '0;
      o_lane_x     = '0;
      o_lane_scale = '0;
      for (int n = 0; n < 3; n++) begin
         yv     = busy[n] ? y_q[n] : 16'd0;
         half_y = yv >> 1;
         if (yv < Y_X2_L) begin
            sc = 2'd0;
            h  = 16'd16;
         end else if (yv < Y_X4_L) begin
            sc = 2'd1;
            h  = 16'd32;
         end else begin
            sc = 2'd2;
            h  = 16'd64;
         end
         case (n)
            0:       xv = CENTER_L - half_y - h;
            1:       xv = CENTER_L - h;
            default: xv = CENTER_L + half_y - h;
         endcase
         if (busy[n]) begin
            o_lane_y[16*n +: 16]   = yv;
            o_lane_x[16*n +: 16]   = xv;
            o_lane_scale[2*n +: 2] = sc;
         end
      end
   end

   assign o_lane_active   = busy[2:0];
   assign o_collect_pulse = collect_pulse_q;
   assign o_miss_pulse    = miss_pulse_q;
   assign o_score         = score_q;

endmodule

// File: tb/tb_coin_lane_scheduler.sv
// Directed bench for coin_lane_scheduler with SPAWN_INTERVAL=4; expected values worked out by hand
// from the seed-0xA5 LFSR sequence (spawns land right, then left, then centre after each reset).
module tb_coin_lane_scheduler;

   logic        clk;
   logic        rst;
   logic        v_sync;
   logic        enable;
   logic [2:0]  collect;
   logic [2:0]  lane_active;
   logic [47:0] lane_y;
   logic [47:0] lane_x;
   logic [5:0]  lane_scale;
   logic        collect_pulse;
   logic        miss_pulse;
   logic [15:0] score;

   int passes = 0;
   int checks = 0;

   coin_lane_scheduler #(
      .SPAWN_INTERVAL(4)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_v_sync       (v_sync),
      .i_enable       (enable),
      .i_collect      (collect),
      .o_lane_active  (lane_active),
      .o_lane_y       (lane_y),
      .o_lane_x       (lane_x),
      .o_lane_scale   (lane_scale),
      .o_collect_pulse(collect_pulse),
      .o_miss_pulse   (miss_pulse),
      .o_score        (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One frame: v_sync high for one cycle; optional collect levels ride on the tick cycle
   task automatic tick(input logic [2:0] col);
      @(negedge clk);
      v_sync  = 1'b1;
      collect = col;
      @(negedge clk);
      v_sync  = 1'b0;
      collect = 3'b000;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(3'b000);
   endtask

   task automatic collect_cycle(input logic [2:0] col);
      @(negedge clk);
      collect = col;
      @(negedge clk);
      collect = 3'b000;
   endtask

   task automatic do_reset(input logic vs_at_release);
      @(negedge clk);
      rst    = 1'b1;
      v_sync = vs_at_release;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      v_sync = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      v_sync  = 1'b0;
      enable  = 1'b0;
      collect = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_active", 64'(lane_active), 64'd0);
      check("rst_y", 64'(lane_y), 64'd0);
      check("rst_x", 64'(lane_x), 64'd0);
      check("rst_scale", 64'(lane_scale), 64'd0);
      check("rst_pulses", 64'({collect_pulse, miss_pulse}), 64'd0);
      check("rst_score", 64'(score), 64'd0);

      // First spawn on the 4th tick, right lane (lfsr 0x2A)
      enable = 1'b1;
      ticks(3);
      check("pre_spawn_active", 64'(lane_active), 64'd0);
      tick(3'b000);
      check("spawn1_active", 64'(lane_active), 64'b100);
      check("spawn1_y", 64'(lane_y), 64'd0);
      check("spawn1_x", 64'(lane_x), 64'({16'd624, 32'd0}));
      check("spawn1_scale", 64'(lane_scale), 64'd0);
      enable = 1'b0;

      // Fall and scale boundaries on the right lane
      ticks(299);
      check("y299", 64'(lane_y[47:32]), 64'd299);
      check("y299_scale", 64'(lane_scale[5:4]), 64'd0);
      check("y299_x", 64'(lane_x[47:32]), 64'd773);
      tick(3'b000);
      check("y300", 64'(lane_y[47:32]), 64'd300);
      check("y300_scale", 64'(lane_scale[5:4]), 64'd1);
      check("y300_x", 64'(lane_x[47:32]), 64'd758);
      ticks(149);
      check("y449_scale", 64'(lane_scale[5:4]), 64'd1);
      check("y449_x", 64'(lane_x[47:32]), 64'd832);
      tick(3'b000);
      check("y450_scale", 64'(lane_scale[5:4]), 64'd2);
      check("y450_x", 64'(lane_x[47:32]), 64'd801);

      // Miss at Y_END
      ticks(142);
      check("y592", 64'(lane_y[47:32]), 64'd592);
      check("y592_active", 64'(lane_active), 64'b100);
      check("y592_no_miss", 64'(miss_pulse), 64'd0);
      tick(3'b000);
      check("miss_active", 64'(lane_active), 64'd0);
      check("miss_pulse", 64'(miss_pulse), 64'd1);
      check("miss_score", 64'(score), 64'd0);
      check("miss_outputs", 64'(lane_y | lane_x), 64'd0);
      @(negedge clk);
      check("miss_pulse_1cyc", 64'(miss_pulse), 64'd0);

      // Collect window: right lane spawns at tick 4, left at tick 8 (lfsr 0xA7)
      do_reset(1'b0);
      enable = 1'b1;
      ticks(8);
      check("two_active", 64'(lane_active), 64'b101);
      check("two_y", 64'(lane_y), 64'({16'd4, 16'd0, 16'd0}));
      enable = 1'b0;
      ticks(143);
      check("left_y143", 64'(lane_y[15:0]), 64'd143);
      collect_cycle(3'b001);
      check("col143_active", 64'(lane_active), 64'b101);
      check("col143_score", 64'(score), 64'd0);
      check("col143_pulse", 64'(collect_pulse), 64'd0);
      tick(3'b000);
      check("left_x144", 64'(lane_x[15:0]), 64'd552);
      collect_cycle(3'b001);
      check("col144_active", 64'(lane_active), 64'b100);
      check("col144_score", 64'(score), 64'd1);
      check("col144_pulse", 64'(collect_pulse), 64'd1);
      @(negedge clk);
      check("col144_pulse_1cyc", 64'(collect_pulse), 64'd0);
      ticks(444);
      check("right_y592", 64'(lane_y[47:32]), 64'd592);
      tick(3'b100);
      check("col592_active", 64'(lane_active), 64'd0);
      check("col592_score", 64'(score), 64'd2);
      check("col592_pulse", 64'(collect_pulse), 64'd1);
      check("col592_no_miss", 64'(miss_pulse), 64'd0);

      // Asynchronous reset clears without a clock edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_score", 64'(score), 64'd0);

      // v_sync high at release is not a tick; fill all lanes (centre via fallback, lfsr 0x77)
      do_reset(1'b1);
      enable = 1'b1;
      ticks(3);
      check("vs_release_no_tick", 64'(lane_active), 64'd0);
      ticks(9);
      check("full_active", 64'(lane_active), 64'b111);
      check("full_y", 64'(lane_y), 64'({16'd8, 16'd0, 16'd4}));
      check("full_x", 64'(lane_x), 64'({16'd628, 16'd624, 16'd622}));
      ticks(4);
      check("drop_active", 64'(lane_active), 64'b111);
      check("drop_y", 64'(lane_y), 64'({16'd12, 16'd4, 16'd8}));
      enable = 1'b0;
      ticks(10);
      check("hold_fall_y", 64'(lane_y), 64'({16'd22, 16'd14, 16'd18}));
      ticks(130);
      collect_cycle(3'b111);
      check("col3_active", 64'(lane_active), 64'd0);
      check("col3_score", 64'(score), 64'd3);
      check("col3_pulse", 64'(collect_pulse), 64'd1);
      enable = 1'b1;
      ticks(3);
      check("cnt_restart_active", 64'(lane_active), 64'd0);
      tick(3'b000);
      check("cnt_restart_spawn", 64'($countones(lane_active)), 64'd1);
      ticks(4);
      check("second_spawn", 64'($countones(lane_active)), 64'd2);
      enable = 1'b0;
      ticks(150);

      // Score saturation with two lanes collected together
      @(negedge clk);
      force dut.score_q = 16'hFFFE;
      #1;
      release dut.score_q;
      check("preload_score", 64'(score), 64'hFFFE);
      collect_cycle(3'b111);
      check("sat_score", 64'(score), 64'hFFFF);
      check("sat_pulse", 64'(collect_pulse), 64'd1);
      check("sat_active", 64'(lane_active), 64'd0);
      @(negedge clk);
      check("sat_pulse_1cyc", 64'(collect_pulse), 64'd0);
      check("sat_score_hold", 64'(score), 64'hFFFF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/coin_lane_scheduler.md
# coin_lane_scheduler

Frame-rate scheduler for the three perspective coin lanes (left, centre, right) of the road scene. It decides when and in which lane a coin spawns, advances each coin's depth once per frame, and selects the x1/x2/x4 scale bucket. It retires coins on collection or miss and keeps the score. It sits between the video timing generator (v_sync) and the per-lane coin sprite renderers, which become pure position-driven lookups.

## Interface
- SPAWN_INTERVAL, 120: frames between spawn attempts (2..255).
- Y_END, 592: depth at which a coin is retired as missed (720-128).
- Y_X2, 300: y threshold for x2 scale. Y_X4, 450: y threshold for x4 scale.
- HIT_Y_MIN, 144: smallest y at which a collect is accepted.
- CENTER_X, 640: vanishing-point x.
- LFSR_SEED, 8'hA5: non-zero reset value of the lane-select LFSR.
- i_clk  in  1  system/pixel clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_v_sync  in  1  vertical sync from timing generator, synchronous to i_clk.
- i_enable  in  1  spawning allowed; falling coins keep moving when low.
- i_collect  in  3  per-lane player-collision level, {right, centre, left}.
- o_lane_active  out  3  lane holds a live coin.
- o_lane_y  out  48  three 16-bit coin tops, lane n at [16n+15:16n].
- o_lane_x  out  48  three 16-bit coin lefts, same packing.
- o_lane_scale  out  6  2 bits per lane: 0=x1, 1=x2, 2=x4.
- o_collect_pulse  out  1  one-cycle pulse per cycle in which at least one coin is collected.
- o_miss_pulse  out  1  one-cycle pulse per cycle in which at least one coin is missed.
- o_score  out  16  collected-coin count, saturating.

## Operation
- Frame tick: rising edge of i_v_sync, detected as i_v_sync & ~v_sync_q. It lasts exactly one cycle.
- Per-lane state is IDLE or FALL, with a 16-bit y register.
- On tick, a FALL lane with y >= Y_END goes to IDLE and raises a miss. Any other FALL lane does y <= y+1.
- Scale is combinational from registered y: y < Y_X2 gives 0, y < Y_X4 gives 1, otherwise 2. Half-width h is 16, 32 or 64 for scale 0, 1, 2.
- Lane x values:
  - left: CENTER_X - (y>>1) - h
  - centre: CENTER_X - h
  - right: CENTER_X + (y>>1) - h
- IDLE lanes output y=0, x=0, scale=0.
- Spawn counter (8 bit) increments on tick only when i_enable=1.
- At count SPAWN_INTERVAL-1, the counter clears and a spawn attempt is made:
  - The preferred lane is lfsr[1:0]; value 3 maps to lane 0.
  - If the preferred lane is busy, try the next lane cyclically (0→1→2→0).
  - If all lanes are busy, the attempt is dropped.
  - The chosen lane goes to FALL with y=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances on every tick.
- Collect: a FALL lane with i_collect[n]=1 and y >= HIT_Y_MIN goes to IDLE.
  - o_score += popcount of the lanes collected this cycle, saturating at 16'hFFFF.
  - A collect asserted below HIT_Y_MIN is ignored.
- Priority in one cycle:
  - Collect beats miss for the same lane: score, no miss.
  - Spawn uses lane state registered at cycle start, so a lane collected this cycle still counts as busy.
- i_enable low: the counter holds, no spawns. Collect and miss still operate.

## Timing
- Reset values:
  - all lanes IDLE; all o_lane_* outputs 0; pulses 0; o_score 0
  - spawn counter 0; lfsr LFSR_SEED; v_sync_q 0
- The first spawn occurs on the SPAWN_INTERVAL-th tick after reset with i_enable=1.
- Lane state, y, score and pulses update on the clock edge that ends the tick or collect cycle, i.e. 1-cycle latency. x and scale follow y combinationally.
- Pulses are high for exactly one cycle and are registered.
- Reset asserted mid-frame clears everything immediately. An i_v_sync that is already high at reset release is not a tick.

## Configuration
- COIN_SCHED_SPEEDUP_EN defined: the effective interval starts at SPAWN_INTERVAL and drops by 1 after every 8 collected coins, with a floor of 30. Reset restores SPAWN_INTERVAL.
- COIN_SCHED_SPEEDUP_EN undefined: the interval is fixed at SPAWN_INTERVAL and no extra logic is present.

## Test plan
- Reset/first spawn: SPAWN_INTERVAL=4, seed 8'hA5, i_enable=1, 4 ticks.
  - Required: exactly one lane goes active with y=0 after the 4th tick, all other outputs 0.
- Fall and scale: single active right lane, 300 ticks.
  - Required: y=300, scale=1, x=640+150-32=758.
  - At y=450: scale=2, x=640+225-64=801.
- Miss: active lane run to y=592, then one more tick.
  - Required: lane IDLE, o_miss_pulse high for 1 cycle, o_score unchanged.
- Collect window:
  - i_collect on the left lane at y=143: ignored.
  - i_collect at y=144: lane IDLE, o_score=1, o_collect_pulse for 1 cycle.
  - Collect at y=592 on the same cycle as the tick: o_score increments and there is no miss.
- Full lanes: all three lanes active, spawn attempt due.
  - Required: no lane changes and the counter restarts at 0.
  - With i_enable=0 over 10 ticks the counter holds and the coins still fall.
- Score: preload near saturation by forcing score to 16'hFFFE, then collect 2 lanes in the same cycle.
  - Required: o_score=16'hFFFF and a single o_collect_pulse.
